// File: rtl/s_mem_verify_if.sv
// s_mem_verify_if: handshake and RAM read bus between the S-array verifier and its controller
interface s_mem_verify_if;
  logic       In_Start;
  logic       Finish_ack;
  logic [7:0] q_data;
  logic [7:0] Address;
  logic       wren;
  logic       Busy;
  logic       Verify_Finish;
  logic       Pass;
  logic [8:0] Err_Count;
  logic [7:0] First_Err_Addr;
  logic [7:0] First_Err_Data;
  modport master (
    output In_Start, Finish_ack, q_data,
    input  Address, wren, Busy, Verify_Finish, Pass, Err_Count, First_Err_Addr, First_Err_Data
  );
  modport slave (
    input  In_Start, Finish_ack, q_data,
    output Address, wren, Busy, Verify_Finish, Pass, Err_Count, First_Err_Addr, First_Err_Data
  );
endinterface

// File: rtl/s_mem_verify.sv
// s_mem_verify: sweeps the 256-byte S-array and checks s[i] == i after the init pass
module s_mem_verify #(
  parameter int READ_LATENCY = 1
) (
  input logic          CLOCK_50,
  input logic          rst,
  s_mem_verify_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] addr_n;
  logic [READ_LATENCY-1:0] tv;
  logic [7:0] ta [READ_LATENCY];
  logic first_seen, hit, miss, last;
  assign hit  = tv[READ_LATENCY-1];
  assign miss = hit && (bus.q_data != ta[READ_LATENCY-1]);
  assign last = hit && (ta[READ_LATENCY-1] == 8'hFF);
  assign bus.wren = 1'b0;
  assign bus.Busy = (state == ISSUE) || (state == DRAIN);
  assign bus.Verify_Finish = (state == DONE);
  always_comb begin
    state_n = IDLE;
    addr_n  = 8'd0;
    case (state)
      IDLE:  state_n = bus.In_Start ? ISSUE : IDLE;
      ISSUE: begin
        state_n = (bus.Address == 8'hFF) ? DRAIN : ISSUE;
        addr_n  = (bus.Address == 8'hFF) ? bus.Address : bus.Address + 8'd1;
      end
      DRAIN: begin
        state_n = last ? DONE : DRAIN;
        addr_n  = bus.Address;
      end
      DONE: begin
        state_n = bus.Finish_ack ? IDLE : DONE;
        addr_n  = bus.Finish_ack ? 8'd0 : bus.Address;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bus.Address        <= 8'd0;
      bus.Pass           <= 1'b0;
      bus.Err_Count      <= 9'd0;
      bus.First_Err_Addr <= 8'd0;
      bus.First_Err_Data <= 8'd0;
      first_seen         <= 1'b0;
      tv                 <= '0;
      for (int i = 0; i < READ_LATENCY; i++) ta[i] <= 8'd0;
    end else begin
      state       <= state_n;
      bus.Address <= addr_n;
      tv[0]       <= (state == ISSUE);
      ta[0]       <= bus.Address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tv[i] <= tv[i-1];
        ta[i] <= ta[i-1];
      end
      if (state == IDLE && bus.In_Start) begin
        bus.Pass           <= 1'b0;
        bus.Err_Count      <= 9'd0;
        bus.First_Err_Addr <= 8'd0;
        bus.First_Err_Data <= 8'd0;
        first_seen         <= 1'b0;
      end else if (miss) begin
        bus.Err_Count <= bus.Err_Count + 9'd1;
        if (!first_seen) begin
          first_seen         <= 1'b1;
          bus.First_Err_Addr <= ta[READ_LATENCY-1];
          bus.First_Err_Data <= bus.q_data;
        end
      end
      // the final compare lands on the same edge, so fold it into the verdict
      if (state == DRAIN && last) bus.Pass <= !miss && (bus.Err_Count == 9'd0);
    end
  end
endmodule

// File: doc/s_mem_verify.md
# s_mem_verify

Read-back checker for the 256-byte RC4 S-array working memory. On a start pulse it sweeps addresses 0..255 and compares each returned byte against the identity pattern (s[i] == i). That pattern is what the initialisation FSM writes, so this block is the reading side of that interface. It sits on the same single-port RAM address/q bus between the init pass and the key-scheduling pass. It reports pass/fail, the error count and the first mismatch through the same start / finish / acknowledge handshake as the other pass FSMs.

## Interface
Parameters:
- READ_LATENCY, default 1: cycles from Address presented to q valid. Legal values are 1..3.

Ports:
- CLOCK_50  in  1: system clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- In_Start  in  1: start request; sampled only in IDLE.
- Finish_ack  in  1: acknowledge of Verify_Finish; sampled only in DONE.
- q_data  in  8: RAM read data.
- Address  out  8: RAM address.
- wren  out  1: RAM write enable; constant 0 (drives the shared bus mux).
- Busy  out  1: high in ISSUE and DRAIN.
- Verify_Finish  out  1: high only in DONE.
- Pass  out  1: 1 when Err_Count == 0; meaningful only while Verify_Finish = 1.
- Err_Count  out  9: number of mismatching addresses, 0..256.
- First_Err_Addr  out  8: address of the lowest mismatch.
- First_Err_Data  out  8: q_data read at First_Err_Addr.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE; any illegal encoding goes to IDLE.
- IDLE:
  - Address = 0.
  - If In_Start = 1: go to ISSUE, and clear Err_Count, First_Err_Addr, First_Err_Data and the first-error flag.
- ISSUE:
  - Address = 0 on the first cycle, then +1 every cycle.
  - Each issued address enters a READ_LATENCY-deep tag pipeline as {valid, addr}.
  - After the cycle that presents Address = 255, go to DRAIN. Address stays at 255; no wrap is issued.
- DRAIN: no new tags. After the last valid tag has been compared, go to DONE.
- Compare (ISSUE and DRAIN): at each edge where the pipeline output tag is valid, compare q_data with the tag address.
  - On mismatch: Err_Count += 1.
  - If this is the first mismatch: capture the tag address into First_Err_Addr and q_data into First_Err_Data.
- DONE:
  - All result outputs are held stable.
  - Finish_ack = 1 goes to IDLE, and results stay held in IDLE until the next start.
  - Finish_ack = 0 stays in DONE.
- The sweep never stops early; all 256 addresses are always compared.
- Err_Count is 9 bits and cannot overflow (maximum 256).
- Ignored inputs:
  - In_Start outside IDLE is ignored.
  - Finish_ack outside DONE is ignored.
  - Finish_ack and In_Start high together in DONE: go to IDLE only. A new sweep starts on the following edge if In_Start is still high.

## Timing
- Reset values: all outputs 0; state IDLE; tag pipeline all invalid.
- Reset asserted mid-sweep returns everything to reset values immediately. The partial results are discarded.
- Edge E0 samples In_Start = 1 in IDLE.
- Cycle k (k = 1..256) presents Address = k-1.
- The compare for address a occurs at the edge ending cycle a+1+READ_LATENCY.
- Verify_Finish rises in cycle 257+READ_LATENCY: 258 for L = 1, 259 for L = 2.
- Busy is high in cycles 1..256+READ_LATENCY.
- Pass, Err_Count and the First_Err fields are final when Verify_Finish rises.
- Finish_ack sampled at the edge ending a DONE cycle: the next cycle is IDLE with Verify_Finish = 0.

## Test plan
- Identity memory, L = 1, one-cycle start pulse:
  - Verify_Finish rises exactly 258 cycles after the start edge.
  - Pass = 1, Err_Count = 0.
  - Address steps 0..255 on consecutive cycles.
- Corrupt s[0x7F] = 0x00: Pass = 0, Err_Count = 1, First_Err_Addr = 0x7F, First_Err_Data = 0x00.
- Corrupt s[0x10] = 0xAA and s[0xF0] = 0x01, L = 2:
  - Err_Count = 2, First_Err_Addr = 0x10, First_Err_Data = 0xAA.
  - Verify_Finish rises at cycle 259.
- All-zero memory: Err_Count = 255, First_Err_Addr = 0x01, First_Err_Data = 0x00, Pass = 0.
- Handshake:
  - Hold Finish_ack low for 20 cycles: DONE and the results stay stable.
  - Pulse Finish_ack: IDLE next cycle.
  - In_Start held high continuously: a new sweep begins one cycle after IDLE, with results cleared.
- Reset mid-sweep:
  - Assert rst at Address = 0x64: all outputs are 0 immediately.
  - A subsequent start on identity memory gives Pass = 1 with nominal timing.
